// File: rtl/keypad_matrix_scan_pkg.sv
// keypad_matrix_scan_pkg: shared FSM state encoding and width helper for the keypad scanner.
package keypad_matrix_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASING
    } state_e;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/keypad_matrix_scan_if.sv
// keypad_matrix_scan_if: matrix drive/sense lines plus decoded key outputs.
interface keypad_matrix_scan_if
    import keypad_matrix_scan_pkg::*;
#(
    parameter int NUM_COLS = 3,
    parameter int NUM_ROWS = 4
) ();

    localparam int KEYS   = NUM_ROWS * NUM_COLS;
    localparam int CODE_W = clog2(KEYS);

    logic [NUM_ROWS-1:0] key_row;
    logic [NUM_COLS-1:0] key_col;
    logic [KEYS-1:0]     key_data;
    logic [CODE_W-1:0]   key_code;
    logic                key_valid;
    logic                key_release;
    logic                key_multi;

    modport master (
        input  key_row,
        output key_col, key_data, key_code, key_valid, key_release, key_multi
    );

    modport slave (
        output key_row,
        input  key_col, key_data, key_code, key_valid, key_release, key_multi
    );

endinterface

// File: rtl/keypad_matrix_scan_tick_gen.sv
// scan_tick_gen: free-running divider emitting a one-clk tick every DIV cycles.
module scan_tick_gen
    import keypad_matrix_scan_pkg::*;
#(
    parameter int DIV = 125000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            W    = clog2(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;

    assign tick = cnt_q == LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= tick ? '0 : cnt_q + W'(1);
    end

endmodule

// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan: column-scanning keypad controller with press/release debounce.
module keypad_matrix_scan
    import keypad_matrix_scan_pkg::*;
#(
    parameter int NUM_COLS       = 3,
    parameter int NUM_ROWS       = 4,
    parameter int SCAN_DIV       = 125000,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic clk,
    input  logic rst,
    keypad_matrix_scan_if.master kp
);

    localparam int             KEYS    = NUM_ROWS * NUM_COLS;
    localparam int             CODE_W  = clog2(KEYS);
    localparam int             DBW     = clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DBW-1:0] DS_LAST = DBW'(DEBOUNCE_SCANS - 1);

    state_e              state_q;
    logic [NUM_COLS-1:0] col_q;
    logic [NUM_ROWS-1:0] row_q;
    logic [DBW-1:0]      cnt_q;
    logic [KEYS-1:0]     data_q;
    logic [CODE_W-1:0]   code_q;
    logic                valid_q;
    logic                release_q;
    logic                multi_q;
    logic                issued_q;
    logic                tick;

    logic [CODE_W-1:0]   row_idx;
    logic [CODE_W-1:0]   col_idx;
    logic [CODE_W-1:0]   code_d;
    logic [NUM_COLS-1:0] col_rot_d;
    logic                multi_d;

    scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        row_idx = '0;
        col_idx = '0;
        for (int i = 0; i < NUM_ROWS; i++) if (row_q[i]) row_idx = CODE_W'(i);
        for (int i = 0; i < NUM_COLS; i++) if (col_q[i]) col_idx = CODE_W'(i);
        code_d    = CODE_W'(int'(row_idx) * NUM_COLS) + col_idx;
        col_rot_d = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
        multi_d   = |(row_q & (row_q - NUM_ROWS'(1)));
    end

    // cnt_q counts matching ticks already seen; reaching DS_LAST means this tick completes the run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            release_q <= 1'b0;
            multi_q   <= 1'b0;
            issued_q  <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            release_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    IDLE: begin
                        state_q <= SCAN;
                        col_q   <= NUM_COLS'(1);
                    end
                    SCAN: begin
                        if (kp.key_row == '0) begin
                            col_q <= col_rot_d;
                        end else begin
                            row_q   <= kp.key_row;
                            cnt_q   <= '0;
                            state_q <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (kp.key_row != row_q) begin
                            state_q <= SCAN;
                        end else if (cnt_q == DS_LAST) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                            if (multi_d) begin
                                multi_q <= 1'b1;
                            end else begin
                                data_q   <= KEYS'(1) << code_d;
                                code_q   <= code_d;
                                valid_q  <= 1'b1;
                                issued_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + DBW'(1);
                        end
                    end
                    PRESSED, RELEASING: begin
                        if (kp.key_row != '0) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                        end else if (cnt_q == DS_LAST) begin
                            state_q   <= SCAN;
                            cnt_q     <= '0;
                            release_q <= issued_q;
                            issued_q  <= 1'b0;
                            data_q    <= '0;
                            multi_q   <= 1'b0;
                            col_q     <= col_rot_d;
                        end else begin
                            state_q <= RELEASING;
                            cnt_q   <= cnt_q + DBW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign kp.key_col     = col_q;
    assign kp.key_data    = data_q;
    assign kp.key_code    = code_q;
    assign kp.key_valid   = valid_q;
    assign kp.key_release = release_q;
    assign kp.key_multi   = multi_q;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// tb_keypad_matrix_scan: directed scan/press/bounce/release/multi/reset checks on a 3x4 keypad.
module tb_keypad_matrix_scan;

    localparam int NC  = 3;
    localparam int NR  = 4;
    localparam int DIV = 4;
    localparam int DS  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   valid_cnt = 0;
    int   rel_cnt = 0;
    int   overlap = 0;

    keypad_matrix_scan_if #(.NUM_COLS(NC), .NUM_ROWS(NR)) kp ();

    keypad_matrix_scan #(
        .NUM_COLS       (NC),
        .NUM_ROWS       (NR),
        .SCAN_DIV       (DIV),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    logic [21:0] outs;
    assign outs = {kp.key_col, kp.key_data, kp.key_code, kp.key_valid, kp.key_release, kp.key_multi};

    always @(negedge clk) begin
        if (rst) begin
            valid_cnt += int'(kp.key_valid);
            rel_cnt   += int'(kp.key_release);
            overlap   += int'(kp.key_valid & kp.key_release);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        kp.key_row = '0;
        @(negedge clk);
        chk("reset_outputs", 32'(outs), 32'h0);
        step(2);
        rst = 1'b1;
        // scan rotation
        step(3);
        chk("no_tick_before_div", 32'(kp.key_col), 32'h0);
        step(1);
        chk("tick1_col", 32'(kp.key_col), 32'h1);
        step(3);
        chk("col_held_between_ticks", 32'(kp.key_col), 32'h1);
        step(1);
        chk("tick2_col", 32'(kp.key_col), 32'h2);
        step(4);
        chk("tick3_col", 32'(kp.key_col), 32'h4);
        step(4);
        chk("tick4_wrap_col", 32'(kp.key_col), 32'h1);
        step(4);
        chk("tick5_col", 32'(kp.key_col), 32'h2);
        // press key 4 (row 1, col 1)
        kp.key_row = 4'b0010;
        step(4);
        chk("latch_col_hold", 32'(kp.key_col), 32'h2);
        chk("latch_no_valid", 32'(kp.key_valid), 32'h0);
        step(4);
        chk("debounce_no_valid", 32'(kp.key_valid), 32'h0);
        step(4);
        chk("press_valid", 32'(kp.key_valid), 32'h1);
        chk("press_code", 32'(kp.key_code), 32'h4);
        chk("press_data", 32'(kp.key_data), 32'h010);
        chk("press_multi", 32'(kp.key_multi), 32'h0);
        step(1);
        chk("valid_one_clk", 32'(kp.key_valid), 32'h0);
        chk("valid_count_press", 32'(valid_cnt), 32'h1);
        step(3);
        kp.key_row = 4'b0011;
        step(4);
        chk("pressed_ignores_change", 32'({kp.key_col, kp.key_data, kp.key_valid}), 32'({3'b010, 12'h010, 1'b0}));
        // release
        kp.key_row = 4'b0000;
        step(4);
        chk("releasing_no_pulse", 32'({kp.key_release, kp.key_data}), 32'({1'b0, 12'h010}));
        step(4);
        chk("release_pulse", 32'(kp.key_release), 32'h1);
        chk("release_data_clear", 32'(kp.key_data), 32'h0);
        chk("release_code_kept", 32'(kp.key_code), 32'h4);
        chk("release_next_col", 32'(kp.key_col), 32'h4);
        step(1);
        chk("release_one_clk", 32'(kp.key_release), 32'h0);
        step(3);
        chk("tick13_col", 32'(kp.key_col), 32'h1);
        // bounce in column 0
        kp.key_row = 4'b0001;
        step(4);
        kp.key_row = 4'b0000;
        step(4);
        chk("bounce_col_held", 32'(kp.key_col), 32'h1);
        kp.key_row = 4'b0001;
        step(4);
        kp.key_row = 4'b0000;
        step(4);
        chk("bounce_col0", 32'(kp.key_col), 32'h1);
        chk("bounce_no_valid", 32'(valid_cnt), 32'h1);
        step(4);
        chk("bounce_resume_col", 32'(kp.key_col), 32'h2);
        step(4);
        step(4);
        chk("tick20_col", 32'(kp.key_col), 32'h1);
        // two rows in column 0
        kp.key_row = 4'b1001;
        step(12);
        chk("multi_set", 32'(kp.key_multi), 32'h1);
        chk("multi_no_valid", 32'(kp.key_valid), 32'h0);
        chk("multi_data_code", 32'({kp.key_data, kp.key_code}), 32'({12'h000, 4'h4}));
        kp.key_row = 4'b0000;
        step(4);
        chk("multi_hold_releasing", 32'(kp.key_multi), 32'h1);
        step(4);
        chk("multi_cleared", 32'(kp.key_multi), 32'h0);
        chk("multi_no_release", 32'(kp.key_release), 32'h0);
        chk("multi_next_col", 32'(kp.key_col), 32'h2);
        kp.key_row = 4'b0010;
        step(1);
        chk("release_count", 32'(rel_cnt), 32'h1);
        chk("valid_count_multi", 32'(valid_cnt), 32'h1);
        // press again, then reset while held
        step(11);
        chk("repress_valid", 32'({kp.key_valid, kp.key_data}), 32'({1'b1, 12'h010}));
        step(1);
        rst = 1'b0;
        #1;
        chk("reset_mid_press", 32'(outs), 32'h0);
        step(2);
        kp.key_row = 4'b0000;
        rst = 1'b1;
        step(3);
        chk("restart_no_tick", 32'(kp.key_col), 32'h0);
        step(1);
        chk("restart_tick_col", 32'(kp.key_col), 32'h1);
        chk("no_overlap", 32'(overlap), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
